// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with hold, flush and built-in load-use bubble insertion.
// Optional `PIPE_STATS_EN adds free-running bubble/hold event counters.
module id_ex_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_i,
  input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [DATA_WIDTH-1:0] id_pc_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic [2:0]            id_funct3_i,
  input  logic                  id_funct7_i,
  input  logic [2:0]            id_alu_op_i,
  input  logic [7:0]            id_ctrl_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic [2:0]            ex_funct3_o,
  output logic                  ex_funct7_o,
  output logic [2:0]            ex_alu_op_o,
  output logic [7:0]            ex_ctrl_o,
`ifdef PIPE_STATS_EN
  output logic [31:0]           bubble_count_o,
  output logic [31:0]           hold_count_o,
`endif
  output logic                  load_use_stall_o
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [2:0]            funct3;
    logic                  funct7;
    logic [2:0]            alu_op;
    logic [7:0]            ctrl;
  } id_ex_t;

  localparam int CTRL_MEM_READ = 6;

  id_ex_t ex_q, ex_d, id_in;
  logic   load_use;
  logic   bubble_load;
  logic   hold_load;

  // An invalid decode slot is captured as a bubble so it can never write state.
  always_comb begin
    id_in          = '0;
    id_in.valid    = id_valid_i;
    id_in.rs1_data = id_rs1_data_i;
    id_in.rs2_data = id_rs2_data_i;
    id_in.imm      = id_imm_i;
    id_in.pc       = id_pc_i;
    id_in.rs1_addr = id_rs1_addr_i;
    id_in.rs2_addr = id_rs2_addr_i;
    if (id_valid_i) begin
      id_in.rd_addr = id_rd_addr_i;
      id_in.funct3  = id_funct3_i;
      id_in.funct7  = id_funct7_i;
      id_in.alu_op  = id_alu_op_i;
      id_in.ctrl    = id_ctrl_i;
    end
  end

  assign load_use = ~flush_i & ex_q.valid & ex_q.ctrl[CTRL_MEM_READ] & id_valid_i &
                    (ex_q.rd_addr != '0) &
                    ((ex_q.rd_addr == id_rs1_addr_i) | (ex_q.rd_addr == id_rs2_addr_i));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ex_d        = ex_q;
    bubble_load = 1'b0;
    hold_load   = 1'b0;
    if (flush_i) begin
      ex_d        = '0;
      bubble_load = 1'b1;
    end else if (stall_i) begin
      hold_load   = 1'b1;
    end else if (load_use) begin
      ex_d        = '0;
      bubble_load = 1'b1;
    end else begin
      ex_d        = id_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

`ifdef PIPE_STATS_EN
  logic [31:0] bubble_cnt_q, hold_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      if (bubble_load) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (hold_load)   hold_cnt_q   <= hold_cnt_q + 32'd1;
    end
  end

  assign bubble_count_o = bubble_cnt_q;
  assign hold_count_o   = hold_cnt_q;
`endif

  assign ex_valid_o       = ex_q.valid;
  assign ex_rs1_data_o    = ex_q.rs1_data;
  assign ex_rs2_data_o    = ex_q.rs2_data;
  assign ex_imm_o         = ex_q.imm;
  assign ex_pc_o          = ex_q.pc;
  assign ex_rs1_addr_o    = ex_q.rs1_addr;
  assign ex_rs2_addr_o    = ex_q.rs2_addr;
  assign ex_rd_addr_o     = ex_q.rd_addr;
  assign ex_funct3_o      = ex_q.funct3;
  assign ex_funct7_o      = ex_q.funct7;
  assign ex_alu_op_o      = ex_q.alu_op;
  assign ex_ctrl_o        = ex_q.ctrl;
  assign load_use_stall_o = load_use;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Self-checking bench for id_ex_stage_register: directed scenarios plus randomized
// traffic compared every cycle against a behavioural pipeline-slot model.
module tb_id_ex_stage_register;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid_i;
  logic [DW-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i;
  logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [2:0]    id_funct3_i;
  logic          id_funct7_i;
  logic [2:0]    id_alu_op_i;
  logic [7:0]    id_ctrl_i;
  logic          stall_i, flush_i;

  logic          ex_valid_o;
  logic [DW-1:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
  logic [AW-1:0] ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic [2:0]    ex_funct3_o;
  logic          ex_funct7_o;
  logic [2:0]    ex_alu_op_o;
  logic [7:0]    ex_ctrl_o;
  logic          load_use_stall_o;
`ifdef PIPE_STATS_EN
  logic [31:0]   bubble_count_o, hold_count_o;
`endif

  id_ex_stage_register #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_funct3_i(id_funct3_i), .id_funct7_i(id_funct7_i),
    .id_alu_op_i(id_alu_op_i), .id_ctrl_i(id_ctrl_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_ctrl_o(ex_ctrl_o),
`ifdef PIPE_STATS_EN
    .bubble_count_o(bubble_count_o), .hold_count_o(hold_count_o),
`endif
    .load_use_stall_o(load_use_stall_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the EX slot holds one instruction record (or an empty bubble).
  typedef struct {
    bit          valid;
    logic [DW-1:0] rs1d, rs2d, imm, pc;
    logic [AW-1:0] rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [2:0]  op;
    logic [7:0]  ctrl;
  } slot_t;

  slot_t m_ex;
  int    m_bubbles;
  int    m_holds;

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.rs1d = '0; s.rs2d = '0; s.imm = '0; s.pc = '0;
    s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.f3 = '0; s.f7 = 1'b0; s.op = '0; s.ctrl = '0;
    return s;
  endfunction

  // A load in EX blocks a decode-slot instruction that reads its (non-x0) destination.
  function automatic bit model_hazard();
    if (flush_i || !id_valid_i) return 0;
    if (!(m_ex.valid && m_ex.ctrl[6])) return 0;
    if (m_ex.rd == 0) return 0;
    return (m_ex.rd == id_rs1_addr_i) || (m_ex.rd == id_rs2_addr_i);
  endfunction

  function automatic slot_t decode_slot();
    slot_t s = empty_slot();
    s.rs1d = id_rs1_data_i; s.rs2d = id_rs2_data_i; s.imm = id_imm_i; s.pc = id_pc_i;
    s.rs1  = id_rs1_addr_i; s.rs2  = id_rs2_addr_i;
    if (id_valid_i) begin
      s.valid = 1; s.rd = id_rd_addr_i; s.f3 = id_funct3_i; s.f7 = id_funct7_i;
      s.op = id_alu_op_i; s.ctrl = id_ctrl_i;
    end
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ex = empty_slot(); m_bubbles = 0; m_holds = 0;
    end else if (flush_i) begin
      m_ex = empty_slot(); m_bubbles++;
    end else if (stall_i) begin
      m_holds++;
    end else if (model_hazard()) begin
      m_ex = empty_slot(); m_bubbles++;
    end else begin
      m_ex = decode_slot();
    end
  end

  // Single compare process, on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_valid",  {63'd0, ex_valid_o}, {63'd0, m_ex.valid});
      check("cmp_rs1d",   64'(ex_rs1_data_o), 64'(m_ex.rs1d));
      check("cmp_rs2d",   64'(ex_rs2_data_o), 64'(m_ex.rs2d));
      check("cmp_imm",    64'(ex_imm_o),      64'(m_ex.imm));
      check("cmp_pc",     64'(ex_pc_o),       64'(m_ex.pc));
      check("cmp_addrs",  64'({ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o}),
                          64'({m_ex.rs1, m_ex.rs2, m_ex.rd}));
      check("cmp_alu",    64'({ex_alu_op_o, ex_funct3_o, ex_funct7_o}),
                          64'({m_ex.op, m_ex.f3, m_ex.f7}));
      check("cmp_ctrl",   64'(ex_ctrl_o),     64'(m_ex.ctrl));
      check("cmp_lu",     {63'd0, load_use_stall_o}, {63'd0, model_hazard()});
`ifdef PIPE_STATS_EN
      check("cmp_bubcnt", 64'(bubble_count_o), 64'(32'(m_bubbles)));
      check("cmp_holdcnt", 64'(hold_count_o),  64'(32'(m_holds)));
`endif
    end
  end

  task automatic set_inst(input bit v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic [7:0] ctrl, input logic [2:0] f3);
    id_valid_i    = v;
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
    id_ctrl_i     = ctrl; id_funct3_i = f3; id_funct7_i = 1'b0; id_alu_op_i = 3'b000;
    id_rs1_data_i = 32'h1000_0000 | 32'(rs1);
    id_rs2_data_i = 32'h2000_0000 | 32'(rs2);
    id_imm_i      = 32'h0000_0040;
    id_pc_i       = 32'h0000_0100 + 32'(rd) * 4;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] all_outputs_or();
    return 64'(ex_valid_o | (|ex_rs1_data_o) | (|ex_rs2_data_o) | (|ex_imm_o) | (|ex_pc_o) |
                (|ex_rs1_addr_o) | (|ex_rs2_addr_o) | (|ex_rd_addr_o) | (|ex_funct3_o) |
                ex_funct7_o | (|ex_alu_op_o) | (|ex_ctrl_o) | load_use_stall_o);
  endfunction

  localparam logic [7:0] CTRL_ADD = 8'h80;  // reg_write
  localparam logic [7:0] CTRL_LW  = 8'hD8;  // reg_write, mem_read, mem_to_reg, alu_src

`ifdef PIPE_STATS_EN
  logic [31:0] bub_before, hold_before;
`endif

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    set_inst(0, 0, 0, 0, 8'h00, 3'd0);
    #1;
    check("reset_outputs_zero", all_outputs_or(), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    chk_en = 1'b1;

    // Normal flow: add x3,x1,x2
    set_inst(1, 1, 2, 3, CTRL_ADD, 3'd0);
    tick();
    check("add_valid", {63'd0, ex_valid_o}, 64'd1);
    check("add_rd",    64'(ex_rd_addr_o), 64'd3);
    check("add_ctrl",  64'(ex_ctrl_o), 64'h80);
    check("add_rs1d",  64'(ex_rs1_data_o), 64'h1000_0001);
    check("add_pc",    64'(ex_pc_o), 64'h10C);

    // Load-use: lw x5 then add x6,x5,x2
    set_inst(1, 1, 0, 5, CTRL_LW, 3'd2);
    tick();
    set_inst(1, 5, 2, 6, CTRL_ADD, 3'd0);
    #1 check("lu_stall_asserted", {63'd0, load_use_stall_o}, 64'd1);
    tick();
    check("lu_bubble_ctrl",  64'(ex_ctrl_o), 64'd0);
    check("lu_bubble_valid", {63'd0, ex_valid_o}, 64'd0);
    check("lu_bubble_rd",    64'(ex_rd_addr_o), 64'd0);
    check("lu_stall_cleared", {63'd0, load_use_stall_o}, 64'd0);
    tick();
    check("lu_dependent_rd",    64'(ex_rd_addr_o), 64'd6);
    check("lu_dependent_valid", {63'd0, ex_valid_o}, 64'd1);

    // lw x0 followed by a reader of x0: no hazard
    set_inst(1, 1, 0, 0, CTRL_LW, 3'd2);
    tick();
    set_inst(1, 0, 0, 7, CTRL_ADD, 3'd0);
    #1 check("x0_no_stall", {63'd0, load_use_stall_o}, 64'd0);
    tick();
    check("x0_no_bubble_rd", 64'(ex_rd_addr_o), 64'd7);

    // External stall for 3 edges while a load-use is pending
    set_inst(1, 1, 0, 5, CTRL_LW, 3'd2);
    tick();
    set_inst(1, 1, 5, 8, CTRL_ADD, 3'd0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_rd",   64'(ex_rd_addr_o), 64'd5);
      check("stall_hold_ctrl", 64'(ex_ctrl_o), 64'hD8);
      check("stall_lu_kept",   {63'd0, load_use_stall_o}, 64'd1);
    end
    stall_i = 1'b0;
    tick();
    check("stall_then_bubble", 64'({ex_valid_o, ex_ctrl_o}), 64'd0);
    tick();
    check("stall_then_dep_rd", 64'(ex_rd_addr_o), 64'd8);

    // Flush and stall together, with a hazard present: flush wins
    set_inst(1, 1, 0, 5, CTRL_LW, 3'd2);
    tick();
    set_inst(1, 5, 0, 9, CTRL_ADD, 3'd0);
    flush_i = 1'b1; stall_i = 1'b1;
`ifdef PIPE_STATS_EN
    bub_before = bubble_count_o; hold_before = hold_count_o;
`endif
    #1 check("flush_forces_lu_low", {63'd0, load_use_stall_o}, 64'd0);
    tick();
    check("flush_stall_bubble", 64'({ex_valid_o, ex_ctrl_o, ex_rd_addr_o}), 64'd0);
`ifdef PIPE_STATS_EN
    check("flush_bubble_cnt_inc", 64'(bubble_count_o - bub_before), 64'd1);
    check("flush_hold_cnt_same",  64'(hold_count_o), 64'(hold_before));
`endif
    flush_i = 1'b0; stall_i = 1'b0;

    // Reset asserted mid-cycle during a held load-use
    set_inst(1, 1, 0, 5, CTRL_LW, 3'd2);
    tick();
    set_inst(1, 5, 0, 10, CTRL_ADD, 3'd0);
    stall_i = 1'b1;
    #1;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1 check("async_reset_immediate", all_outputs_or(), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    stall_i = 1'b0;
    chk_en = 1'b1;
    #1 check("post_reset_no_hazard", {63'd0, load_use_stall_o}, 64'd0);

    // Randomized traffic; small register range makes hazards frequent
    for (int c = 0; c < 2000; c++) begin
      id_valid_i    = ($urandom_range(0, 7) != 0);
      id_rs1_addr_i = AW'($urandom_range(0, 5));
      id_rs2_addr_i = AW'($urandom_range(0, 5));
      id_rd_addr_i  = AW'($urandom_range(0, 5));
      id_ctrl_i     = 8'($urandom);
      if ($urandom_range(0, 1) == 1) id_ctrl_i[6] = 1'b1;
      id_funct3_i   = 3'($urandom);
      id_funct7_i   = 1'($urandom);
      id_alu_op_i   = 3'($urandom);
      id_rs1_data_i = $urandom;
      id_rs2_data_i = $urandom;
      id_imm_i      = $urandom;
      id_pc_i       = $urandom;
      stall_i       = ($urandom_range(0, 7) == 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- Pipeline register between decode and execute in the 5-stage RISC-V core.
- Captures decoded operands, register addresses and control fields, including the ALU_Op/funct3/funct7 triple consumed by the ALU control decoder in EX.
- Supports hold (stall), flush (bubble) and built-in load-use hazard detection that generates a bubble plus an upstream stall request.

Parameters:
DATA_WIDTH, 32, width of operands, immediate and PC fields
REG_ADDR_W, 5, register-file address width

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid_i  input  1  decode slot holds a real instruction
id_rs1_data_i  input  DATA_WIDTH  rs1 read data
id_rs2_data_i  input  DATA_WIDTH  rs2 read data
id_imm_i  input  DATA_WIDTH  sign-extended immediate
id_pc_i  input  DATA_WIDTH  instruction PC
id_rs1_addr_i  input  REG_ADDR_W  rs1 index
id_rs2_addr_i  input  REG_ADDR_W  rs2 index
id_rd_addr_i  input  REG_ADDR_W  destination index
id_funct3_i  input  3  instruction funct3
id_funct7_i  input  1  instruction bit 30
id_alu_op_i  input  3  decoder ALU_Op class
id_ctrl_i  input  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, jalr}
stall_i  input  1  external hold (e.g. data-memory wait)
flush_i  input  1  branch/jump redirect kill
ex_valid_o  output  1  EX slot valid
ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  output  DATA_WIDTH each  registered copies
ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  output  REG_ADDR_W each  registered copies
ex_funct3_o  output  3  registered funct3
ex_funct7_o  output  1  registered funct7 bit
ex_alu_op_o  output  3  registered ALU_Op
ex_ctrl_o  output  8  registered control bits
load_use_stall_o  output  1  combinational: hold PC and IF/ID this cycle

Behaviour:
- Reset (async, immediate): all outputs 0. The bubble value decodes as ADD with no side effects.
- load_use_stall_o = ex_valid_o & ex_ctrl_o[6] (mem_read) & id_valid_i & (ex_rd_addr_o != 0) & (ex_rd_addr_o == id_rs1_addr_i | ex_rd_addr_o == id_rs2_addr_i). Forced 0 when flush_i = 1.
- Per rising edge, priority order:
  1. flush_i: load bubble (valid, ctrl, alu_op, funct3, funct7 = 0; rd_addr = 0). Data fields don't-care; implementation loads 0.
  2. stall_i: hold all registers unchanged. A hold also holds a pending load-use: load_use_stall_o stays asserted while stall_i = 1.
  3. load_use_stall_o: load bubble, identical to flush.
  4. Otherwise: capture all id_* inputs. If id_valid_i = 0, the bubble encoding is captured instead of the id_ctrl_i/alu fields.
- Latency: 1 cycle from ID capture to EX outputs. A load-use inserts exactly 1 bubble, then the dependent instruction enters EX.
- rs1 or rs2 equal to x0 never triggers a hazard, even when the load targets x0 (rd = 0 is excluded).
- Simultaneous flush_i and stall_i: flush wins.
- A bubble never asserts reg_write, mem_write or branch.
- Reset mid-stall clears everything; there is no post-reset hazard.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs bubble_count_o[31:0] and hold_count_o[31:0].
  - bubble_count_o increments on every edge where a flush or load-use bubble is loaded.
  - hold_count_o increments on every edge where stall_i is honoured.
  - Both counters wrap 0xFFFFFFFF -> 0 and are cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-cycle with registers loaded -> all outputs 0 immediately, before the next clk edge.
- Normal flow: ID add x3,x1,x2 (alu_op=000, funct3=000, funct7=0, ctrl=0x80) -> EX fields equal after 1 edge, ex_valid_o=1.
- Load-use: EX holds lw x5 (mem_read=1, rd=5), ID has rs1=5 -> load_use_stall_o=1, next EX = bubble (ctrl=0), following edge captures the dependent instruction.
- lw x0 followed by use of x0 -> load_use_stall_o=0, no bubble.
- stall_i=1 for 3 edges while the load-use condition holds -> EX unchanged for 3 edges, load_use_stall_o stays 1, bubble inserted on the first edge after stall_i drops.
- flush_i=1 and stall_i=1 together -> bubble loaded. With PIPE_STATS_EN defined, bubble_count_o increments by 1 and hold_count_o is unchanged.
